// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline.
// Holds or bubbles pipeline registers when forwarding cannot supply an operand:
// data-memory wait states, multi-cycle divides in EX, taken branches in EX and
// load-use hazards, in that priority order. Also counts PC-stall cycles.
module hazard_stall_unit #(
    parameter int DIV_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_Rs1,
    input  logic [4:0]       IF_ID_Rs2,
    input  logic             IF_ID_UseRs1,
    input  logic             IF_ID_UseRs2,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Rd,
    input  logic             ID_EX_IsDiv,
    input  logic             EX_BranchTaken,
    input  logic             MEM_Req,
    input  logic             MEM_Ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Write,
    output logic             EX_MEM_Flush,
    output logic             MEM_WB_Flush,
    output logic             Div_Busy,
    output logic [CNT_W-1:0] Stall_Count
);

    // Counter only needs to hold DIV_LATENCY-2 (the DIV-state dwell after entry).
    localparam int DCW = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY - 1) : 1;
    localparam logic [DCW-1:0] DIV_LOAD = (DIV_LATENCY > 1) ? DCW'(DIV_LATENCY - 2) : '0;
    localparam logic DIV_EN = (DIV_LATENCY > 1);

    typedef enum logic {S_RUN, S_DIV} state_t;

    state_t           state_q;
    logic [DCW-1:0]   div_cnt_q;
    logic             div_busy_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic       mem_stall;
    logic       div_stall;
    logic       load_use;
    logic [4:0] src_rs  [2];
    logic       src_use [2];
    logic [1:0] src_hit;

    assign src_rs[0]  = IF_ID_Rs1;
    assign src_rs[1]  = IF_ID_Rs2;
    assign src_use[0] = IF_ID_UseRs1;
    assign src_use[1] = IF_ID_UseRs2;

    // Per-operand comparison against the load destination in EX; x0 never matches.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi] && (ID_EX_Rd == src_rs[gi]) && (ID_EX_Rd != 5'd0);
        end
    endgenerate

    assign mem_stall = MEM_Req && !MEM_Ready;
    assign div_stall = ((state_q == S_RUN) && ID_EX_IsDiv && DIV_EN) ||
                       ((state_q == S_DIV) && (div_cnt_q != '0));
    assign load_use  = !mem_stall && !div_stall && !EX_BranchTaken &&
                       ID_EX_MemRead && (|src_hit);

    // Pipeline register controls, priority: mem wait > divide > branch > load-use.
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Write  = 1'b1;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Write = 1'b1;
        EX_MEM_Flush = 1'b0;
        MEM_WB_Flush = 1'b0;
        if (mem_stall) begin
            // Freeze everything up to EX/MEM; hazards in frozen stages wait for release.
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Flush = 1'b1;
        end else if (div_stall) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Flush = 1'b1;
        end else if (EX_BranchTaken) begin
            // PC stays enabled so it loads the branch target.
            IF_ID_Flush  = 1'b1;
            ID_EX_Flush  = 1'b1;
        end else if (load_use) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Flush  = 1'b1;
        end
    end

    // Divider occupancy FSM; the countdown keeps running through memory waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            div_cnt_q  <= '0;
            div_busy_q <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (ID_EX_IsDiv && DIV_EN) begin
                        state_q    <= S_DIV;
                        div_cnt_q  <= DIV_LOAD;
                        div_busy_q <= 1'b1;
                    end
                end
                S_DIV: begin
                    if (div_cnt_q != '0) begin
                        div_cnt_q <= div_cnt_q - DCW'(1);
                    end else if (!mem_stall) begin
                        state_q    <= S_RUN;
                        div_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_RUN;
                    div_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign stall_cnt_d = (!PC_Write && (stall_cnt_q != {CNT_W{1'b1}})) ?
                         stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Div_Busy    = div_busy_q;
    assign Stall_Count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: each cycle's expected controls are
// queued when stimulus is applied and compared at the following falling edge.
module tb_hazard_stall_unit;

    localparam int CW = 4;

    // Expected control vector bit order:
    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
    //  EX_MEM_Write, EX_MEM_Flush, MEM_WB_Flush, Div_Busy}
    localparam logic [8:0] DEF  = 9'b110101000;
    localparam logic [8:0] LU   = 9'b000111000;
    localparam logic [8:0] DIVS = 9'b000001100;
    localparam logic [8:0] MEMS = 9'b000000010;
    localparam logic [8:0] BR   = 9'b111111000;
    localparam logic [8:0] B    = 9'b000000001;

    logic          clk;
    logic          rst_n;
    logic [4:0]    IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd;
    logic          IF_ID_UseRs1, IF_ID_UseRs2, ID_EX_MemRead, ID_EX_IsDiv;
    logic          EX_BranchTaken, MEM_Req, MEM_Ready;
    logic          PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush;
    logic          EX_MEM_Write, EX_MEM_Flush, MEM_WB_Flush, Div_Busy;
    logic [CW-1:0] Stall_Count;

    typedef struct {
        logic [8:0]    ctrl;
        logic [CW-1:0] cnt;
        string         tag;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          e;
    int            n_cmp;
    int            n_err;
    logic [CW-1:0] exp_cnt;

    hazard_stall_unit #(.DIV_LATENCY(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2),
        .IF_ID_UseRs1(IF_ID_UseRs1), .IF_ID_UseRs2(IF_ID_UseRs2),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd), .ID_EX_IsDiv(ID_EX_IsDiv),
        .EX_BranchTaken(EX_BranchTaken), .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush),
        .EX_MEM_Write(EX_MEM_Write), .EX_MEM_Flush(EX_MEM_Flush),
        .MEM_WB_Flush(MEM_WB_Flush), .Div_Busy(Div_Busy), .Stall_Count(Stall_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] obs_ctrl();
        return {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
                EX_MEM_Write, EX_MEM_Flush, MEM_WB_Flush, Div_Busy};
    endfunction

    // Apply one cycle of stimulus and queue what the pipeline controls must be.
    // The stall-count model advances whenever the expected PC_Write is 0.
    task automatic drive(input string tag, input logic mr, input logic [4:0] rd,
                         input logic u1, input logic [4:0] rs1,
                         input logic u2, input logic [4:0] rs2,
                         input logic dv, input logic br, input logic rq, input logic rdy,
                         input logic [8:0] ctrl);
        exp_t x;
        ID_EX_MemRead  = mr;
        ID_EX_Rd       = rd;
        IF_ID_UseRs1   = u1;
        IF_ID_Rs1      = rs1;
        IF_ID_UseRs2   = u2;
        IF_ID_Rs2      = rs2;
        ID_EX_IsDiv    = dv;
        EX_BranchTaken = br;
        MEM_Req        = rq;
        MEM_Ready      = rdy;
        x.ctrl = ctrl;
        x.cnt  = exp_cnt;
        x.tag  = tag;
        sb_q.push_back(x);
        if (!ctrl[8] && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic idle(input string tag, input logic [8:0] ctrl);
        drive(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ctrl);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        exp_cnt = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        idle("reset", DEF);
        @(negedge clk);
        e = sb_q.pop_front();
        n_cmp++;
        if (obs_ctrl() !== e.ctrl) begin
            n_err++;
            $display("FAIL %s ctrl got %b want %b", e.tag, obs_ctrl(), e.ctrl);
        end
        n_cmp++;
        if (Stall_Count !== e.cnt) begin
            n_err++;
            $display("FAIL %s stall_count got %0d want %0d", e.tag, Stall_Count, e.cnt);
        end
        $display("txn %s ctrl=%b cnt=%0d", e.tag, obs_ctrl(), Stall_Count);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive("lu_rs2", 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, LU);
                1: idle("lu_bubble", DEF);
                2: drive("x0_nostall", 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, DEF);
                3: drive("nouse_nostall", 1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, DEF);
                4: drive("lu_rs1", 1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, LU);
                default: drive("noload_match", 1'b0, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, DEF);
            endcase
            @(negedge clk);
            e = sb_q.pop_front();
            n_cmp++;
            if (obs_ctrl() !== e.ctrl) begin
                n_err++;
                $display("FAIL %s ctrl got %b want %b", e.tag, obs_ctrl(), e.ctrl);
            end
            n_cmp++;
            if (Stall_Count !== e.cnt) begin
                n_err++;
                $display("FAIL %s stall_count got %0d want %0d", e.tag, Stall_Count, e.cnt);
            end
            $display("txn %s ctrl=%b cnt=%0d", e.tag, obs_ctrl(), Stall_Count);
            @(posedge clk);
            #1;
        end
    endtask

    // Two divides back to back, each stalling DIV_LATENCY-1 = 3 cycles.
    task automatic test_back_to_back();
        for (int i = 0; i < 9; i++) begin
            case (i)
                0, 4:    drive("div_start", 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, DIVS);
                1, 2, 5, 6: drive("div_busy", 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, DIVS | B);
                3, 7:    drive("div_done", 1'b0, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, DEF | B);
                default: idle("div_after", DEF);
            endcase
            @(negedge clk);
            e = sb_q.pop_front();
            n_cmp++;
            if (obs_ctrl() !== e.ctrl) begin
                n_err++;
                $display("FAIL %s ctrl got %b want %b", e.tag, obs_ctrl(), e.ctrl);
            end
            n_cmp++;
            if (Stall_Count !== e.cnt) begin
                n_err++;
                $display("FAIL %s stall_count got %0d want %0d", e.tag, Stall_Count, e.cnt);
            end
            $display("txn %s ctrl=%b cnt=%0d", e.tag, obs_ctrl(), Stall_Count);
            @(posedge clk);
            #1;
        end
    endtask

    // Memory wait freezes a taken branch and a load-use; both act after release.
    task automatic test_mem_branch();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0, 1: drive("mem_br", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, MEMS);
                2:    drive("br_release", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR);
                3:    drive("br_over_lu", 1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR);
                4:    drive("mem_ready", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, DEF);
                5:    drive("mem_lu", 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, MEMS);
                6:    drive("lu_release", 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, LU);
                default: idle("mem_after", DEF);
            endcase
            @(negedge clk);
            e = sb_q.pop_front();
            n_cmp++;
            if (obs_ctrl() !== e.ctrl) begin
                n_err++;
                $display("FAIL %s ctrl got %b want %b", e.tag, obs_ctrl(), e.ctrl);
            end
            n_cmp++;
            if (Stall_Count !== e.cnt) begin
                n_err++;
                $display("FAIL %s stall_count got %0d want %0d", e.tag, Stall_Count, e.cnt);
            end
            $display("txn %s ctrl=%b cnt=%0d", e.tag, obs_ctrl(), Stall_Count);
            @(posedge clk);
            #1;
        end
    endtask

    // Memory wait in divide cycles 3-5: FSM parks at cnt=0 until it clears.
    task automatic test_div_mem();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0:       drive("dm_start", 1'b0, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, DIVS);
                1:       drive("dm_busy", 1'b0, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, DIVS | B);
                2, 3, 4: drive("dm_memwait", 1'b0, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, MEMS | B);
                5:       drive("dm_release", 1'b0, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, DEF | B);
                default: idle("dm_after", DEF);
            endcase
            @(negedge clk);
            e = sb_q.pop_front();
            n_cmp++;
            if (obs_ctrl() !== e.ctrl) begin
                n_err++;
                $display("FAIL %s ctrl got %b want %b", e.tag, obs_ctrl(), e.ctrl);
            end
            n_cmp++;
            if (Stall_Count !== e.cnt) begin
                n_err++;
                $display("FAIL %s stall_count got %0d want %0d", e.tag, Stall_Count, e.cnt);
            end
            $display("txn %s ctrl=%b cnt=%0d", e.tag, obs_ctrl(), Stall_Count);
            @(posedge clk);
            #1;
        end
    endtask

    // Asynchronous reset in the middle of a divide clears busy and the counter at once.
    task automatic test_reset_mid_div();
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                rst_n   = 1'b0;
                exp_cnt = '0;
            end
            case (i)
                0:       drive("rd_start", 1'b0, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, DIVS);
                1:       drive("rd_busy", 1'b0, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, DIVS | B);
                2:       idle("rd_inreset", DEF);
                default: idle("rd_after", DEF);
            endcase
            @(negedge clk);
            e = sb_q.pop_front();
            n_cmp++;
            if (obs_ctrl() !== e.ctrl) begin
                n_err++;
                $display("FAIL %s ctrl got %b want %b", e.tag, obs_ctrl(), e.ctrl);
            end
            n_cmp++;
            if (Stall_Count !== e.cnt) begin
                n_err++;
                $display("FAIL %s stall_count got %0d want %0d", e.tag, Stall_Count, e.cnt);
            end
            $display("txn %s ctrl=%b cnt=%0d", e.tag, obs_ctrl(), Stall_Count);
            if (i == 2) rst_n = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    // Continuous load-use stalls drive the narrow counter into saturation.
    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            drive("sat_lu", 1'b1, 5'd12, 1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, LU);
            @(negedge clk);
            e = sb_q.pop_front();
            n_cmp++;
            if (obs_ctrl() !== e.ctrl) begin
                n_err++;
                $display("FAIL %s ctrl got %b want %b", e.tag, obs_ctrl(), e.ctrl);
            end
            n_cmp++;
            if (Stall_Count !== e.cnt) begin
                n_err++;
                $display("FAIL %s stall_count got %0d want %0d", e.tag, Stall_Count, e.cnt);
            end
            $display("txn %s ctrl=%b cnt=%0d", e.tag, obs_ctrl(), Stall_Count);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        exp_cnt        = '0;
        rst_n          = 1'b0;
        IF_ID_Rs1      = '0;
        IF_ID_Rs2      = '0;
        ID_EX_Rd       = '0;
        IF_ID_UseRs1   = 1'b0;
        IF_ID_UseRs2   = 1'b0;
        ID_EX_MemRead  = 1'b0;
        ID_EX_IsDiv    = 1'b0;
        EX_BranchTaken = 1'b0;
        MEM_Req        = 1'b0;
        MEM_Ready      = 1'b0;
        test_reset();
        test_load_use();
        test_back_to_back();
        test_mem_branch();
        test_div_mem();
        test_reset_mid_div();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage pipeline; the counterpart of the forwarding unit. Forwarding supplies operands. This block holds or bubbles the pipeline when forwarding cannot supply an operand.
- It detects load-use hazards, multi-cycle divide occupancy in EX, data-memory wait states and taken branches in EX.
- It drives the write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
DIV_LATENCY, 4, cycles a divide occupies EX (>=1; 1 means no divide stall)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
IF_ID_Rs1  in  5  rs1 of instruction in ID
IF_ID_Rs2  in  5  rs2 of instruction in ID
IF_ID_UseRs1  in  1  ID instruction reads rs1
IF_ID_UseRs2  in  1  ID instruction reads rs2
ID_EX_MemRead  in  1  instruction in EX is a load
ID_EX_Rd  in  5  destination of instruction in EX
ID_EX_IsDiv  in  1  instruction in EX is a divide/remainder
EX_BranchTaken  in  1  valid taken branch/jump resolved in EX
MEM_Req  in  1  load/store present in MEM
MEM_Ready  in  1  data memory completes access this cycle
PC_Write  out  1  PC update enable
IF_ID_Write  out  1  IF/ID register enable
IF_ID_Flush  out  1  IF/ID loaded with NOP
ID_EX_Write  out  1  ID/EX register enable
ID_EX_Flush  out  1  ID/EX loaded with bubble (controls zeroed)
EX_MEM_Write  out  1  EX/MEM register enable
EX_MEM_Flush  out  1  EX/MEM loaded with bubble
MEM_WB_Flush  out  1  MEM/WB loaded with bubble
Div_Busy  out  1  divider FSM in DIV state
Stall_Count  out  CNT_W  cycles with PC_Write=0, saturating

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, div counter=0, Stall_Count=0, Div_Busy=0.
  - Remaining outputs are combinational from state and inputs.
- Default outputs: all *_Write=1, all *_Flush=0.
- mem_stall = MEM_Req & ~MEM_Ready. This condition has highest priority:
  - PC_Write, IF_ID_Write, ID_EX_Write and EX_MEM_Write are all 0.
  - MEM_WB_Flush=1.
  - No other flush is asserted. A branch or load-use present in the frozen stages is held and acted on in the first non-stalled cycle.
- div_stall = (state==RUN & ID_EX_IsDiv & DIV_LATENCY>1) | (state==DIV & cnt!=0).
  - Effect: PC_Write, IF_ID_Write and ID_EX_Write are 0; EX_MEM_Flush=1.
  - The EX/MEM bubble is suppressed while mem_stall is active; the mem_stall outputs apply then.
- Divider FSM, states RUN and DIV:
  - RUN -> DIV when ID_EX_IsDiv & DIV_LATENCY>1. The start is not gated by mem_stall. Load cnt=DIV_LATENCY-2.
  - DIV, cnt!=0: cnt decrements every cycle, including during mem_stall.
  - DIV, cnt==0, ~mem_stall: -> RUN. Divide result is written to EX/MEM this cycle and the next ID/EX instruction advances.
  - DIV, cnt==0, mem_stall: stay in DIV.
  - Total divide stall = DIV_LATENCY-1 cycles absent mem stalls.
  - Back-to-back divides restart from RUN.
- Branch (EX_BranchTaken & ~mem_stall):
  - IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1 (PC loads the target).
  - Overrides load-use.
  - Never coincident with div_stall, because EX holds the divide.
- Load-use, active when all of these hold:
  - ~mem_stall & ~div_stall & ~EX_BranchTaken
  - ID_EX_MemRead & ID_EX_Rd!=0
  - (IF_ID_UseRs1 & Rd==Rs1) | (IF_ID_UseRs2 & Rd==Rs2)
  - Effect: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1.
  - Exactly one bubble; the forwarding path covers the following cycle.
- x0 never causes a stall.
- Stall_Count:
  - +1 on every rising edge where PC_Write=0.
  - Holds at 2^CNT_W-1.
  - Cleared only by reset.
- Reset mid-divide: FSM returns to RUN immediately and all stall outputs deassert.

Test Plan:
- lw x5 in EX (MemRead=1, Rd=5), ID Rs2=5, UseRs2=1 -> one cycle PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Next cycle (ID_EX now bubble) all defaults. Stall_Count=1.
- Load with Rd=0 against Rs1=0, and a load with Rd=5 where UseRs1=UseRs2=0 -> no stall, outputs default.
- DIV_LATENCY=4, divide enters EX -> PC_Write=0 and EX_MEM_Flush=1 for 3 cycles; Div_Busy=1 in cycles 2-4; 4th cycle defaults, state RUN; Stall_Count=3.
- MEM_Req=1, MEM_Ready=0 for 2 cycles while EX_BranchTaken=1 -> 2 cycles of all Writes=0, MEM_WB_Flush=1, no IF_ID_Flush. Then one cycle with IF_ID_Flush=ID_EX_Flush=1, PC_Write=1.
- Divide with DIV_LATENCY=4, mem_stall asserted in cycles 3-5 -> FSM holds DIV at cnt=0 until mem_stall drops, then RUN. Freeze lasts through cycle 5; release in cycle 6.
- rst_n pulsed low during DIV -> Div_Busy=0 and Stall_Count=0 immediately (async); after release, defaults with ID_EX_IsDiv=0.
